// File: rtl/dot_pkg.sv
// Shared constants, glyph type and FSM encoding for the 5x7 dot-matrix character writer.
// Glyphs pack column c into bits [c*ROWS +: ROWS]; bit 0 of each column is the top row.
package dot_pkg;

    localparam int DOT_NUM_COLS    = 5;
    localparam int DOT_ROWS        = 7;
    localparam int DOT_COL_AW      = 5;
    localparam int DOT_HOLD_CYCLES = 3;
    localparam int GLYPH_W         = DOT_NUM_COLS * DOT_ROWS;

    localparam logic [4:0] CH_BLANK = 5'd16;
    localparam logic [4:0] CH_FULL  = 5'd17;

    typedef logic [GLYPH_W-1:0] glyph_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Column 0 is the leftmost column and lands in the least significant slice.
    function automatic glyph_t glyph5(input logic [6:0] c0, input logic [6:0] c1,
                                      input logic [6:0] c2, input logic [6:0] c3,
                                      input logic [6:0] c4);
        return {c4, c3, c2, c1, c0};
    endfunction

endpackage

// File: rtl/dot_font_rom.sv
// 5x7 font ROM for hex digits 0-F, blank and full block; one-clock registered read.
module dot_font_rom
    import dot_pkg::*;
(
    input  logic       clk,
    input  logic [4:0] code,
    output glyph_t     glyph
);

    glyph_t glyph_d;
    glyph_t glyph_q;

    always_comb begin
        glyph_d = '0;
        case (code)
            5'd0:    glyph_d = glyph5(7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E);
            5'd1:    glyph_d = glyph5(7'h00, 7'h42, 7'h7F, 7'h40, 7'h00);
            5'd2:    glyph_d = glyph5(7'h42, 7'h61, 7'h51, 7'h49, 7'h46);
            5'd3:    glyph_d = glyph5(7'h21, 7'h41, 7'h45, 7'h4B, 7'h31);
            5'd4:    glyph_d = glyph5(7'h18, 7'h14, 7'h12, 7'h7F, 7'h10);
            5'd5:    glyph_d = glyph5(7'h27, 7'h45, 7'h45, 7'h45, 7'h39);
            5'd6:    glyph_d = glyph5(7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30);
            5'd7:    glyph_d = glyph5(7'h01, 7'h71, 7'h09, 7'h05, 7'h03);
            5'd8:    glyph_d = glyph5(7'h36, 7'h49, 7'h49, 7'h49, 7'h36);
            5'd9:    glyph_d = glyph5(7'h06, 7'h49, 7'h49, 7'h29, 7'h1E);
            5'd10:   glyph_d = glyph5(7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E);
            5'd11:   glyph_d = glyph5(7'h7F, 7'h49, 7'h49, 7'h49, 7'h36);
            5'd12:   glyph_d = glyph5(7'h3E, 7'h41, 7'h41, 7'h41, 7'h22);
            5'd13:   glyph_d = glyph5(7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C);
            5'd14:   glyph_d = glyph5(7'h7F, 7'h49, 7'h49, 7'h49, 7'h41);
            5'd15:   glyph_d = glyph5(7'h7F, 7'h09, 7'h09, 7'h09, 7'h01);
            CH_FULL: glyph_d = '1;
            default: glyph_d = '0;
        endcase
    end

    // NOTE: no reset on this register; it is pure data and is only consumed after FETCH reloads it.
    always_ff @(posedge clk) begin
        glyph_q <= glyph_d;
    end

    assign glyph = glyph_q;

endmodule

// File: rtl/dot_char_writer.sv
// Glyph write driver for the DotController: one code per handshake, one held write per column, then done.
// Optional feature: define DOT_WRITER_INVERT_EN to add an invert input that inverts character columns.
module dot_char_writer
    import dot_pkg::*;
#(
    parameter int NUM_COLS    = DOT_NUM_COLS,
    parameter int ROWS        = DOT_ROWS,
    parameter int COL_AW      = DOT_COL_AW,
    parameter int HOLD_CYCLES = DOT_HOLD_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        char_code,
    input  logic              char_valid,
`ifdef DOT_WRITER_INVERT_EN
    input  logic              invert,
`endif
    output logic              char_ready,
    input  logic              clear,
    output logic [COL_AW-1:0] colAddr,
    output logic [ROWS-1:0]   rowIn,
    output logic              write,
    output logic              busy,
    output logic              done
);

    localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [COL_AW-1:0] COL_LAST  = COL_AW'(NUM_COLS - 1);

    state_e              state_d, state_q;
    logic [COL_AW-1:0]   col_d, col_q;
    logic [HOLD_W-1:0]   hold_d, hold_q;
    logic [4:0]          code_d, code_q;
    logic                clr_d, clr_q;
`ifdef DOT_WRITER_INVERT_EN
    logic                inv_d, inv_q;
`endif
    logic [COL_AW-1:0]   col_addr_d, col_addr_q;
    logic [ROWS-1:0]     row_in_d, row_in_q;
    logic                write_d, write_q;
    logic                busy_d, busy_q;
    logic                done_d, done_q;
    logic [ROWS-1:0]     col_data;
    glyph_t              glyph;

    dot_font_rom u_rom (
        .clk   (clk),
        .code  (code_q),
        .glyph (glyph)
    );

    assign char_ready = (state_q == IDLE) && !clear;

    // Column slice of the fetched glyph; a clear forces zeros regardless of the latched code.
    always_comb begin
        col_data = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_q == COL_AW'(c)) col_data = glyph[c*ROWS +: ROWS];
        end
        if (clr_q) col_data = '0;
`ifdef DOT_WRITER_INVERT_EN
        else if (inv_q) col_data = ~col_data;
`endif
    end

    // NOTE: every *_d gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        hold_d     = hold_q;
        code_d     = code_q;
        clr_d      = clr_q;
`ifdef DOT_WRITER_INVERT_EN
        inv_d      = inv_q;
`endif
        col_addr_d = '0;
        row_in_d   = '0;
        write_d    = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    clr_d   = 1'b1;
                    state_d = FETCH;
                end else if (char_valid) begin
                    code_d  = char_code;
                    clr_d   = 1'b0;
`ifdef DOT_WRITER_INVERT_EN
                    inv_d   = invert;
`endif
                    state_d = FETCH;
                end
            end
            FETCH: begin
                col_d   = '0;
                hold_d  = HOLD_LAST;
                state_d = WRITE;
            end
            WRITE: begin
                write_d    = 1'b1;
                col_addr_d = col_q;
                row_in_d   = col_data;
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (col_q == COL_LAST) begin
                    state_d = DONE;
                end else begin
                    col_d  = col_q + 1'b1;
                    hold_d = HOLD_LAST;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: reset is synchronous and active-high, so it is tested inside the clocked block only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            hold_q     <= '0;
            code_q     <= '0;
            clr_q      <= 1'b0;
`ifdef DOT_WRITER_INVERT_EN
            inv_q      <= 1'b0;
`endif
            col_addr_q <= '0;
            row_in_q   <= '0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            hold_q     <= hold_d;
            code_q     <= code_d;
            clr_q      <= clr_d;
`ifdef DOT_WRITER_INVERT_EN
            inv_q      <= inv_d;
`endif
            col_addr_q <= col_addr_d;
            row_in_q   <= row_in_d;
            write_q    <= write_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign colAddr = col_addr_q;
    assign rowIn   = row_in_q;
    assign write   = write_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dot_char_writer.sv
// Directed self-checking bench for dot_char_writer: HOLD_CYCLES=3 instance plus a HOLD_CYCLES=1 instance.
// Builds with or without DOT_WRITER_INVERT_EN.
module tb_dot_char_writer;

    logic       clk = 1'b0;
    logic       reset;

    logic [4:0] code0, code1;
    logic       valid0, valid1;
    logic       clear0, clear1;
    logic       inv0, inv1;
    logic       ready0, ready1;
    logic [4:0] addr0, addr1;
    logic [6:0] row0, row1;
    logic       write0, write1;
    logic       busy0, busy1;
    logic       done0, done1;

    logic       sel;
    logic       o_ready, o_write, o_busy, o_done;
    logic [4:0] o_addr;
    logic [6:0] o_row;

    int n_tests = 0;
    int n_fail  = 0;

    logic [34:0] g_one, g_zero, g_five, g_full, g_blank;

    always #5 clk = ~clk;

    dot_char_writer #(.HOLD_CYCLES(3)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .char_code  (code0),
        .char_valid (valid0),
`ifdef DOT_WRITER_INVERT_EN
        .invert     (inv0),
`endif
        .char_ready (ready0),
        .clear      (clear0),
        .colAddr    (addr0),
        .rowIn      (row0),
        .write      (write0),
        .busy       (busy0),
        .done       (done0)
    );

    dot_char_writer #(.HOLD_CYCLES(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .char_code  (code1),
        .char_valid (valid1),
`ifdef DOT_WRITER_INVERT_EN
        .invert     (inv1),
`endif
        .char_ready (ready1),
        .clear      (clear1),
        .colAddr    (addr1),
        .rowIn      (row1),
        .write      (write1),
        .busy       (busy1),
        .done       (done1)
    );

    always_comb begin
        if (sel) begin
            o_ready = ready1; o_write = write1; o_busy = busy1;
            o_done  = done1;  o_addr  = addr1;  o_row  = row1;
        end else begin
            o_ready = ready0; o_write = write0; o_busy = busy0;
            o_done  = done0;  o_addr  = addr0;  o_row  = row0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after the accept edge; follows the whole run up to the done cycle.
    task automatic run_check(input string tag, input logic [34:0] g, input int hold,
                             input bit disturb);
        int         last;
        int         col;
        logic       exp_w;
        logic [6:0] exp_row;
        last = 2 + 5 * hold;
        chk({tag, " busy@0"},  35'(o_busy),  35'(1'b1));
        chk({tag, " write@0"}, 35'(o_write), 35'(1'b0));
        chk({tag, " ready@0"}, 35'(o_ready), 35'(1'b0));
        for (int k = 1; k <= last; k++) begin
            if (disturb) begin
                if (k <= 5 * hold) begin
                    valid0 = k[0];
                    clear0 = (k % 3 == 0);
                    code0  = 5'd17;
                end else begin
                    valid0 = 1'b0;
                    clear0 = 1'b0;
                end
            end
            tick();
            exp_w   = (k >= 2) && (k <= last - 1);
            col     = exp_w ? (k - 2) / hold : 0;
            exp_row = exp_w ? g[col*7 +: 7] : 7'h00;
            chk($sformatf("%s write@%0d", tag, k), 35'(o_write), 35'(exp_w));
            chk($sformatf("%s addr@%0d", tag, k),  35'(o_addr),  35'(col));
            chk($sformatf("%s row@%0d", tag, k),   35'(o_row),   35'(exp_row));
            chk($sformatf("%s done@%0d", tag, k),  35'(o_done),  35'(k == last));
            chk($sformatf("%s busy@%0d", tag, k),  35'(o_busy),  35'(k < last));
        end
        chk({tag, " ready@done"}, 35'(o_ready), 35'(1'b1));
    endtask

    initial begin
        g_one   = {7'h00, 7'h40, 7'h7F, 7'h42, 7'h00};
        g_zero  = {7'h3E, 7'h45, 7'h49, 7'h51, 7'h3E};
        g_five  = {7'h39, 7'h45, 7'h45, 7'h45, 7'h27};
        g_full  = {5{7'h7F}};
        g_blank = '0;

        sel    = 1'b0;
        reset  = 1'b1;
        code0  = 5'd1;  valid0 = 1'b1; clear0 = 1'b0; inv0 = 1'b0;
        code1  = 5'd0;  valid1 = 1'b0; clear1 = 1'b0; inv1 = 1'b0;

        // 1: reset with char_valid held high
        tick();
        tick();
        chk("rst write", 35'(write0), 35'(1'b0));
        chk("rst addr",  35'(addr0),  35'(0));
        chk("rst row",   35'(row0),   35'(0));
        chk("rst busy",  35'(busy0),  35'(1'b0));
        chk("rst done",  35'(done0),  35'(1'b0));
        reset = 1'b0;
        #1;
        chk("rst ready", 35'(ready0), 35'(1'b1));

        // 2: code 1 accepted on the first edge after release
        tick();
        valid0 = 1'b0;
        run_check("one", g_one, 3, 1'b0);
        tick();
        chk("one done low", 35'(done0), 35'(1'b0));

        // 3: clear beats valid, then full block back-to-back after done
        clear0 = 1'b1; valid0 = 1'b1; code0 = 5'd17;
        #1;
        chk("clr ready", 35'(ready0), 35'(1'b0));
        tick();
        clear0 = 1'b0; valid0 = 1'b0;
        run_check("clr", g_blank, 3, 1'b0);
        valid0 = 1'b1; code0 = 5'd17;
        tick();
        valid0 = 1'b0;
        run_check("full", g_full, 3, 1'b0);
        tick();
        chk("full idle write", 35'(write0), 35'(1'b0));
        chk("full idle busy",  35'(busy0),  35'(1'b0));
        tick();
        chk("full no rerun", 35'(busy0), 35'(1'b0));

        // 4: inputs toggled while busy are ignored
        valid0 = 1'b1; code0 = 5'd0;
        tick();
        valid0 = 1'b0;
        run_check("zero", g_zero, 3, 1'b1);
        tick();
        chk("zero idle", 35'(busy0), 35'(1'b0));

        // 5: reset during the column-2 write
        valid0 = 1'b1; code0 = 5'd5;
        tick();
        valid0 = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        chk("abort pre addr",  35'(addr0),  35'(2));
        chk("abort pre row",   35'(row0),   35'(7'h45));
        chk("abort pre write", 35'(write0), 35'(1'b1));
        reset = 1'b1;
        tick();
        chk("abort write", 35'(write0), 35'(1'b0));
        chk("abort busy",  35'(busy0),  35'(1'b0));
        chk("abort done",  35'(done0),  35'(1'b0));
        reset = 1'b0;
        #1;
        chk("abort ready", 35'(ready0), 35'(1'b1));
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("abort quiet@%0d", k), 35'({done0, write0, busy0}), 35'(3'b000));
        end

        // 6: single-cycle hold instance; inverted blank when the feature is built in
        sel = 1'b1;
`ifdef DOT_WRITER_INVERT_EN
        code1 = 5'd16; inv1 = 1'b1;
`else
        code1 = 5'd17;
`endif
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        run_check("h1", g_full, 1, 1'b0);
        tick();
        chk("h1 done low", 35'(done1), 35'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
